// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: write, read, issue, clear and debug signals of the multi-port register file.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     clr_req;
    logic                     init_done;
    logic [ADDR_W-1:0]        debug_addr;
    logic [DATA_W-1:0]        debug_data;
    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, rd_en, rd_addr,
               iss_valid, iss_addr, clr_req, debug_addr,
        input  rd_data, rd_busy, init_done, debug_data
    );
    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, rd_en, rd_addr,
               iss_valid, iss_addr, clr_req, debug_addr,
        output rd_data, rd_busy, init_done, debug_data
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read, dual-write register file with write bypass, busy scoreboard
// and a sequential clear engine so the storage array itself needs no reset.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic             cpu_clk_75M,
    input logic             cpu_rst,
    regfile_mp_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef enum logic {CLEAR, READY} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  cnt, cnt_nxt;
    logic [DEPTH-1:0]   busy, busy_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               init_done, we0_ok, we1_ok, iss_ok;
    logic [ADDR_W-1:0]  ra;
    logic               zr, h0, h1;

    always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
        end
    end

    // The sweep counter parks at DEPTH-1 so it never wraps back to 0 before READY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        if (state == CLEAR) begin
            state_nxt = &cnt ? READY : CLEAR;
            cnt_nxt   = &cnt ? cnt : cnt + 1'b1;
        end else if (bus.clr_req) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
            busy_nxt  = '0;
        end else begin
            if (we0_ok) busy_nxt[bus.waddr0] = 1'b0;
            if (we1_ok) busy_nxt[bus.waddr1] = 1'b0;
            if (iss_ok) busy_nxt[bus.iss_addr] = 1'b1;
        end
    end

    always_comb begin
        init_done = (state == READY);
        we0_ok    = init_done && bus.we0 && !(ZR && bus.waddr0 == '0);
        we1_ok    = init_done && bus.we1 && !(ZR && bus.waddr1 == '0);
        iss_ok    = init_done && bus.iss_valid && !(ZR && bus.iss_addr == '0);
        bus.init_done  = init_done;
        bus.debug_data = mem[bus.debug_addr];
        bus.rd_data    = '0;
        bus.rd_busy    = '0;
        ra = '0;
        zr = 1'b0;
        h0 = 1'b0;
        h1 = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            zr = ZR && ra == '0;
            h1 = bus.we1 && bus.waddr1 == ra;
            h0 = bus.we0 && bus.waddr0 == ra;
            bus.rd_data[k*DATA_W +: DATA_W] = (!init_done || !bus.rd_en[k] || zr) ? '0 :
                                              h1 ? bus.wdata1 : h0 ? bus.wdata0 : mem[ra];
            bus.rd_busy[k] = bus.rd_en[k] && init_done && busy[ra] && !h0 && !h1 && !zr;
        end
    end

    // Port 1 is written last so it wins on an address collision.
    always_ff @(posedge cpu_clk_75M) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (we0_ok) mem[bus.waddr0] <= bus.wdata0;
            if (we1_ok) mem[bus.waddr1] <= bus.wdata1;
        end
    end
endmodule
